// File: rtl/dtw_result_packer.sv
// Serialises DTW match results into 4-word FIFO records and groups them into
// packets of RESULTS_PER_PACKET records, padding partial packets on flush.
module dtw_result_packer #(
    parameter int RESULTS_PER_PACKET = 2,
    parameter int DATA_WIDTH         = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [15:0]           res_query_id,
    input  logic [15:0]           res_ref_id,
    input  logic [31:0]           res_score,
    input  logic [31:0]           res_pos,
    input  logic                  flush_req,
    output logic                  dtw_fifo_wren,
    output logic [DATA_WIDTH-1:0] dtw_fifo_din,
    input  logic                  dtw_fifo_full,
    output logic                  busy,
    output logic                  pkt_done,
    output logic [31:0]           rec_count
);
    localparam int PW = (RESULTS_PER_PACKET > 1) ? $clog2(RESULTS_PER_PACKET) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_PAD} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_word_idx;
    logic [PW-1:0]   r_rec_in_pkt;
    logic [7:0]      r_seq;
    logic            r_flush_pend;
    logic [31:0]     r_rec_count;
    logic            r_pkt_done;
    logic [15:0]     r_qid, r_rid;
    logic [31:0]     r_score, r_pos;

    logic            w_rec_pend, w_capture, w_wr, w_last_wr, w_pkt_wrap, w_flush_drop;
    logic [DATA_WIDTH-1:0] w_din;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rec_pend   = (r_rec_in_pkt != '0);
        res_ready    = (r_state == S_IDLE) && !ARESET && !(r_flush_pend && w_rec_pend);
        w_capture    = res_valid && res_ready;
        w_wr         = (r_state != S_IDLE) && !dtw_fifo_full;
        w_last_wr    = w_wr && (r_word_idx == 2'd3);
        w_pkt_wrap   = w_last_wr && (r_rec_in_pkt == PW'(RESULTS_PER_PACKET - 1));
        // A pending flush with an empty packet is simply dropped, but only
        // when no new result claims this IDLE cycle.
        w_flush_drop = (r_state == S_IDLE) && r_flush_pend && !w_rec_pend && !w_capture;
        w_din        = '0;
        case (r_state)
            S_IDLE: begin
                if (r_flush_pend && w_rec_pend) w_state_nxt = S_PAD;
                else if (w_capture)             w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (w_last_wr) w_state_nxt = S_IDLE;
                case (r_word_idx)
                    2'd0:    w_din = {8'hA5, r_seq, r_qid};
                    2'd1:    w_din = {16'h0000, r_rid};
                    2'd2:    w_din = r_score;
                    default: w_din = r_pos;
                endcase
            end
            S_PAD: begin
                if (w_last_wr) w_state_nxt = S_IDLE;
                w_din = (r_word_idx == 2'd0) ? {8'h5A, r_seq, 16'hFFFF} : 32'hFFFF_FFFF;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_word_idx   <= 2'd0;
            r_rec_in_pkt <= '0;
            r_seq        <= 8'd0;
            r_flush_pend <= 1'b0;
            r_rec_count  <= 32'd0;
            r_pkt_done   <= 1'b0;
            r_qid        <= 16'd0;
            r_rid        <= 16'd0;
            r_score      <= 32'd0;
            r_pos        <= 32'd0;
        end else begin
            r_pkt_done <= w_pkt_wrap;
            if (w_capture && !(r_flush_pend && w_rec_pend)) begin
                r_qid   <= res_query_id;
                r_rid   <= res_ref_id;
                r_score <= res_score;
                r_pos   <= res_pos;
            end
            // 2-bit index rolls back to 0 on the fourth write, ready for the next record
            if (w_wr) r_word_idx <= r_word_idx + 2'd1;
            if (w_last_wr) begin
                r_seq        <= r_seq + 8'd1;
                r_rec_in_pkt <= w_pkt_wrap ? '0 : r_rec_in_pkt + PW'(1);
                if (r_state == S_EMIT) r_rec_count <= r_rec_count + 32'd1;
            end
            if (flush_req)
                r_flush_pend <= 1'b1;
            else if (w_flush_drop || (w_pkt_wrap && r_state == S_PAD))
                r_flush_pend <= 1'b0;
        end
    end

    assign dtw_fifo_wren = w_wr;
    assign dtw_fifo_din  = w_din;
    assign busy          = (r_state != S_IDLE);
    assign pkt_done      = r_pkt_done;
    assign rec_count     = r_rec_count;
endmodule

// File: tb/tb_dtw_result_packer.sv
// Directed bench for dtw_result_packer: record format, packet/pad grouping,
// FIFO backpressure, sequence wrap and asynchronous reset.
module tb_dtw_result_packer;
    logic        ACLK = 1'b0, ARESET = 1'b1;
    logic        res_valid = 1'b0, res_ready, flush_req = 1'b0;
    logic [15:0] res_query_id = '0, res_ref_id = '0;
    logic [31:0] res_score = '0, res_pos = '0;
    logic        dtw_fifo_wren, dtw_fifo_full = 1'b0, busy, pkt_done;
    logic [31:0] dtw_fifo_din, rec_count;

    int          checks = 0, fails = 0, cyc = 0, bad_ready = 0;
    bit          win_en = 0;
    logic [31:0] wq[$];
    int          wc[$];
    int          pd[$];

    dtw_result_packer #(.RESULTS_PER_PACKET(2), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_query_id(res_query_id), .res_ref_id(res_ref_id),
        .res_score(res_score), .res_pos(res_pos),
        .flush_req(flush_req),
        .dtw_fifo_wren(dtw_fifo_wren), .dtw_fifo_din(dtw_fifo_din),
        .dtw_fifo_full(dtw_fifo_full),
        .busy(busy), .pkt_done(pkt_done), .rec_count(rec_count)
    );

    always #5 ACLK = ~ACLK;

    // wren seen at a negedge is committed at the following posedge (full only changes just after posedges)
    always @(negedge ACLK) begin
        cyc++;
        if (win_en && res_ready && wq.size() > 0 && wq.size() < 8) bad_ready++;
        if (dtw_fifo_wren) begin
            wq.push_back(dtw_fifo_din);
            wc.push_back(cyc);
        end
        if (pkt_done) pd.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wq_at(input int i);
        return (i < wq.size()) ? wq[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic int wc_at(input int i);
        return (i < wc.size()) ? wc[i] : -100;
    endfunction
    function automatic int pd_at(input int i);
        return (i < pd.size()) ? pd[i] : -200;
    endfunction

    task automatic clrq();
        wq.delete(); wc.delete(); pd.delete();
    endtask

    task automatic do_reset();
        ARESET = 1'b1; res_valid = 1'b0; flush_req = 1'b0; dtw_fifo_full = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        clrq();
    endtask

    task automatic send(input logic [15:0] q, input logic [15:0] r,
                        input logic [31:0] s, input logic [31:0] p);
        bit ok = 0;
        res_query_id = q; res_ref_id = r; res_score = s; res_pos = p; res_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge ACLK);
            ok = res_ready;
            @(posedge ACLK);
            #1;
        end
        res_valid = 1'b0;
        chk("send_hs", 32'(ok), 32'd1);
    endtask

    task automatic wait_quiet();
        int q = 0;
        for (int i = 0; i < 300 && q < 3; i++) begin
            @(negedge ACLK);
            q = busy ? 0 : q + 1;
        end
        chk("quiet", 32'(q >= 3), 32'd1);
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk4(input string tag, input int base, input logic [31:0] w0,
                        input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        chk({tag, "_w0"}, wq_at(base),     w0);
        chk({tag, "_w1"}, wq_at(base + 1), w1);
        chk({tag, "_w2"}, wq_at(base + 2), w2);
        chk({tag, "_w3"}, wq_at(base + 3), w3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        @(negedge ACLK);
        chk("rst_wren", 32'(dtw_fifo_wren), 32'd0);
        chk("rst_din", dtw_fifo_din, 32'd0);
        chk("rst_ready", 32'(res_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_reccnt", rec_count, 32'd0);
        chk("rst_pktdone", 32'(pkt_done), 32'd0);
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("rel_ready", 32'(res_ready), 32'd1);
        @(posedge ACLK);
        #1;

        // T1: single record, back-to-back words
        clrq();
        send(16'h0003, 16'h0001, 32'd1234, 32'd5000);
        wait_quiet();
        chk("t1_nw", wq.size(), 32'd4);
        chk4("t1", 0, 32'hA500_0003, 32'h0000_0001, 32'h0000_04D2, 32'h0000_1388);
        chk("t1_b2b", 32'(wc_at(3) - wc_at(0)), 32'd3);
        chk("t1_reccnt", rec_count, 32'd1);
        chk("t1_npd", pd.size(), 32'd0);

        // T2: second record closes the packet
        clrq();
        send(16'h0004, 16'h0002, 32'd0, 32'hFFFF_FFFF);
        wait_quiet();
        chk("t2_nw", wq.size(), 32'd4);
        chk4("t2", 0, 32'hA501_0004, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFF);
        chk("t2_npd", pd.size(), 32'd1);
        chk("t2_pdcyc", 32'(pd_at(0)), 32'(wc_at(3) + 1));
        chk("t2_reccnt", rec_count, 32'd2);

        // T3: one record then flush -> pad record
        do_reset();
        bad_ready = 0; win_en = 1;
        send(16'h0007, 16'h0009, 32'd10, 32'd11);
        flush_req = 1'b1;
        @(posedge ACLK);
        #1 flush_req = 1'b0;
        wait_quiet();
        win_en = 0;
        chk("t3_nw", wq.size(), 32'd8);
        chk4("t3_rec", 0, 32'hA500_0007, 32'h0000_0009, 32'h0000_000A, 32'h0000_000B);
        chk4("t3_pad", 4, 32'h5A01_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t3_npd", pd.size(), 32'd1);
        chk("t3_reccnt", rec_count, 32'd1);
        chk("t3_badready", 32'(bad_ready), 32'd0);

        // T4: FIFO full for 3 cycles while word 2 is presented
        clrq();
        send(16'h0010, 16'h0020, 32'h30, 32'h40);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        dtw_fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("t4_wren_hold", 32'(dtw_fifo_wren), 32'd0);
            chk("t4_din_hold", dtw_fifo_din, 32'h30);
            @(posedge ACLK);
            #1;
        end
        dtw_fifo_full = 1'b0;
        wait_quiet();
        chk("t4_nw", wq.size(), 32'd4);
        chk4("t4", 0, 32'hA502_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0040);
        chk("t4_reccnt", rec_count, 32'd2);
        chk("t4_npd", pd.size(), 32'd0);

        // T5: flush on empty packet is a no-op, then 257 records wrap seq
        do_reset();
        flush_req = 1'b1;
        @(posedge ACLK);
        #1 flush_req = 1'b0;
        wait_quiet();
        chk("t5_flush_nw", wq.size(), 32'd0);
        for (int k = 0; k < 257; k++) send(16'(k), 16'(k), 32'(k), 32'(k));
        wait_quiet();
        chk("t5_nw", wq.size(), 32'd1028);
        chk("t5_first", wq_at(0), 32'hA500_0000);
        chk("t5_seqff", wq_at(4 * 255), 32'hA5FF_00FF);
        chk("t5_seqwrap", wq_at(4 * 256), 32'hA500_0100);
        chk("t5_ref256", wq_at(4 * 256 + 1), 32'h0000_0100);
        chk("t5_npd", pd.size(), 32'd128);
        chk("t5_reccnt", rec_count, 32'd257);

        // T6: async reset mid-record
        do_reset();
        send(16'h0005, 16'h0006, 32'd7, 32'd8);
        @(posedge ACLK);
        #3 ARESET = 1'b1;
        #1;
        chk("t6_wren_async", 32'(dtw_fifo_wren), 32'd0);
        chk("t6_din_async", dtw_fifo_din, 32'd0);
        chk("t6_ready_async", 32'(res_ready), 32'd0);
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        clrq();
        @(negedge ACLK);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_reccnt", rec_count, 32'd0);
        chk("t6_ready", 32'(res_ready), 32'd1);
        repeat (3) @(negedge ACLK);
        chk("t6_nw_after", wq.size(), 32'd0);
        @(posedge ACLK);
        #1;
        send(16'h0009, 16'h0000, 32'd0, 32'd0);
        wait_quiet();
        chk("t6_seq0", wq_at(0), 32'hA500_0009);
        chk("t6_reccnt1", rec_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
